axi_demux_n: RTL and testbench
==============================

Name: axi_demux_n

Overview:
- Parametrised AXI-stream packet demultiplexer: one input stream, NUM_CHAN output streams.
- External logic chooses the output per packet from the first line of the packet, which is shown on the `header` port. `dest` is sampled once per packet.
- Successor to the fixed-width 4/8-way demux trees: single flat N-way mux, optional input skid buffer, drop mode for inactive/out-of-range destinations, saturating drop counter.
- Sits between crossbar ingress and per-endpoint FIFOs.

Parameters:
- NUM_CHAN, 8, number of output channels (2..32).
- WIDTH, 64, tdata width.
- DEST_W, 3, width of `dest`; must satisfy 2**DEST_W >= NUM_CHAN.
- ACTIVE_CHAN, all ones (NUM_CHAN bits), bit i=1 means output i is connected.
- BUFFER, 0, 1 inserts a 2-entry input skid buffer (full throughput, +1 cycle latency).
- DROP_INACTIVE, 1, 1 drops packets routed to inactive/out-of-range channels; 0 sends them to channel 0.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active high.
- header  out  WIDTH  first line of the pending packet (valid while hdr_valid=1).
- hdr_valid  out  1  header is presented and `dest` is being sampled.
- dest  in  DEST_W  destination channel for the presented header.
- i_tdata  in  WIDTH  input data.
- i_tlast  in  1  input last.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  NUM_CHAN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- o_tlast  out  NUM_CHAN  per-channel last.
- o_tvalid  out  NUM_CHAN  per-channel valid.
- o_tready  in  NUM_CHAN  per-channel ready.
- drop_count  out  16  packets dropped since reset/clear; saturates at 16'hFFFF.

Behaviour:
- Internal stream `s` is the skid-buffer output when BUFFER=1, otherwise the raw input.
- The skid buffer is 2 entries. i_tready = !full. Data is presented 1 cycle after acceptance. Accepting and emitting in the same cycle is allowed. Flushed by reset and by clear.

State machine (states IDLE, SEND, DROP):
- IDLE:
  - header = s_tdata; hdr_valid = s_tvalid.
  - s_tready = 0; all o_tvalid = 0.
  - On s_tvalid: latch sel <= dest.
  - If dest >= NUM_CHAN or ACTIVE_CHAN[dest]=0: go to DROP when DROP_INACTIVE=1, else latch sel <= 0 and go to SEND.
  - Otherwise go to SEND.
  - The header beat is not consumed in IDLE.
- SEND:
  - o_tvalid[sel] = s_tvalid; o_tdata/o_tlast for channel sel = s_tdata/s_tlast; s_tready = o_tready[sel].
  - All other o_tvalid = 0. o_tdata of non-selected channels mirrors s_tdata (don't-care).
  - On a handshake with s_tlast = 1: go to IDLE.
- DROP:
  - s_tready = 1; no o_tvalid asserted.
  - On a handshake with s_tlast = 1: drop_count increments (saturating), then go to IDLE.

Timing:
- Each packet costs exactly one bubble cycle (the IDLE sampling cycle).
- The first beat is output the cycle after hdr_valid, combinationally from s.
- BUFFER=0: i_tready is combinational from o_tready[sel].

Boundary conditions:
- Single-beat packet (tlast on header): IDLE -> SEND -> IDLE, 2 cycles minimum.
- `dest` changing during SEND is ignored.
- o_tready deasserted mid-packet stalls the input with no data loss. The held beat stays stable on the output until accepted (AXI rule).
- clear in any state: next state IDLE, buffer emptied, drop_count = 0. Beats of a truncated packet that arrive afterwards are treated as a new header (upstream must clear in sync).
- clear and a handshake in the same cycle: clear wins; the handshake beat is still consumed upstream.

Reset values:
- State IDLE, sel = 0, drop_count = 0, buffer empty.
- All o_tvalid = 0, hdr_valid = 0.
- i_tready = 1 for BUFFER=1, 0 for BUFFER=0.

Test Plan:
- NUM_CHAN=8, BUFFER=0, all o_tready=1. Send 4-beat packets with dest=0..7 in turn. Required: each packet appears only on o_tvalid[dest], beats in order, o_tlast on beat 4, 5 cycles per packet.
- ACTIVE_CHAN=8'h0F, DROP_INACTIVE=1. Send packets with dest=5, then dest=2. Required: the first is consumed with no o_tvalid asserted and drop_count=1; the second is delivered on channel 2.
- DROP_INACTIVE=0, NUM_CHAN=6, dest=7. Required: packet delivered on channel 0; drop_count stays 0.
- BUFFER=1. Toggle o_tready[3] randomly (50%) during a 16-beat packet to dest=3. Required: all 16 beats delivered bit-exact, no beat duplicated or lost; i_tready falls only when the 2 entries are full.
- Assert clear at beat 2 of a 6-beat packet to dest=1. Required: next cycle state=IDLE, o_tvalid=0, drop_count=0; beat 3 is presented on header with hdr_valid=1.
- Assert reset_n low asynchronously mid-packet, then send 300 dropped packets. Required: outputs go to their reset values immediately; drop_count reaches 300.

Source files
------------

// File: rtl/axi_demux_n.sv
// AXI-stream packet demux: one input, NUM_CHAN outputs, per-packet dest.
// Optional 2-entry input skid buffer, drop mode and saturating drop counter.
module axi_demux_n #(
  parameter int                  NUM_CHAN      = 8,
  parameter int                  WIDTH         = 64,
  parameter int                  DEST_W        = 3,
  parameter logic [NUM_CHAN-1:0] ACTIVE_CHAN   = '1,
  parameter bit                  BUFFER        = 0,
  parameter bit                  DROP_INACTIVE = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  output logic [WIDTH-1:0]          header,
  output logic                      hdr_valid,
  input  logic [DEST_W-1:0]         dest,
  input  logic [WIDTH-1:0]          i_tdata,
  input  logic                      i_tlast,
  input  logic                      i_tvalid,
  output logic                      i_tready,
  output logic [NUM_CHAN*WIDTH-1:0] o_tdata,
  output logic [NUM_CHAN-1:0]       o_tlast,
  output logic [NUM_CHAN-1:0]       o_tvalid,
  input  logic [NUM_CHAN-1:0]       o_tready,
  output logic [15:0]               drop_count
);

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t              state, state_nxt;
  logic [DEST_W-1:0]   sel, sel_nxt;
  logic [NUM_CHAN-1:0] sel_hot;
  logic                dest_ok;
  logic                drop_inc;
  logic [WIDTH-1:0]    s_tdata;
  logic                s_tlast;
  logic                s_tvalid;
  logic                s_tready;

  if (BUFFER) begin : g_skid
    logic [WIDTH:0] mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     cnt;
    logic           push;
    logic           pop;

    assign i_tready = (cnt != 2'd2);
    assign push     = i_tvalid && i_tready;
    assign pop      = s_tvalid && s_tready;
    assign s_tvalid = (cnt != 2'd0);
    assign s_tdata  = mem[rd_ptr][WIDTH-1:0];
    assign s_tlast  = mem[rd_ptr][WIDTH];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {i_tlast, i_tdata};
    end

    // clear drops a beat pushed in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        cnt    <= 2'd0;
      end else if (clear) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        cnt    <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end else begin : g_pass
    assign s_tdata  = i_tdata;
    assign s_tlast  = i_tlast;
    assign s_tvalid = i_tvalid;
    assign i_tready = s_tready;
  end

  always_comb begin
    dest_ok = 1'b0;
    sel_hot = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (dest == DEST_W'(i) && ACTIVE_CHAN[i]) dest_ok = 1'b1;
      sel_hot[i] = (sel == DEST_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    hdr_valid = 1'b0;
    s_tready  = 1'b0;
    drop_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        hdr_valid = s_tvalid;
        if (s_tvalid) begin
          sel_nxt = dest;
          if (dest_ok) begin
            state_nxt = SEND;
          end else if (DROP_INACTIVE) begin
            state_nxt = DROP;
          end else begin
            sel_nxt   = '0;
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        s_tready = |(o_tready & sel_hot);
        if (s_tvalid && s_tready && s_tlast) state_nxt = IDLE;
      end
      DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      drop_count <= 16'd0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (clear)
        drop_count <= 16'd0;
      else if (drop_inc && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  assign header   = s_tdata;
  assign o_tdata  = {NUM_CHAN{s_tdata}};
  assign o_tlast  = {NUM_CHAN{s_tlast}};
  assign o_tvalid = (state == SEND && s_tvalid) ? sel_hot : '0;

endmodule

// File: tb/tb_axi_demux_n.sv
// Bench for axi_demux_n: three configurations checked against a
// shared scoreboard of {dut, channel, last, data} words.
module tb_axi_demux_n;

  logic clk;
  logic reset_n;

  logic [15:0] id   [3];
  logic        il   [3];
  logic        iv   [3];
  logic        clr  [3];
  logic [2:0]  dst  [3];
  logic [7:0]  ordy [3];

  logic        ir0, ir1, ir2, hv0, hv1, hv2;
  logic [15:0] hd0, hd1, hd2, dc0, dc1, dc2;
  logic [7:0]  ov0, ov1, ol0, ol1;
  logic [5:0]  ov2, ol2;
  logic [127:0] od0, od1;
  logic [95:0]  od2;

  logic        ir [3];
  logic        hv [3];
  logic [15:0] hd [3];
  logic [15:0] dc [3];
  logic [7:0]  ov [3];
  logic [7:0]  ol [3];
  logic [15:0] od [3][8];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q[$];
  bit  rnd_en  = 0;
  bit  chk_occ = 0;
  int  occ     = 0;
  bit  hold_v [3][8];
  logic [16:0] hold_d [3][8];

  axi_demux_n #(.NUM_CHAN(8), .WIDTH(16), .DEST_W(3)) u0 (
    .clk(clk), .reset_n(reset_n), .clear(clr[0]), .header(hd0),
    .hdr_valid(hv0), .dest(dst[0]), .i_tdata(id[0]), .i_tlast(il[0]),
    .i_tvalid(iv[0]), .i_tready(ir0), .o_tdata(od0), .o_tlast(ol0),
    .o_tvalid(ov0), .o_tready(ordy[0]), .drop_count(dc0));

  axi_demux_n #(.NUM_CHAN(8), .WIDTH(16), .DEST_W(3),
    .ACTIVE_CHAN(8'h0F), .BUFFER(1)) u1 (
    .clk(clk), .reset_n(reset_n), .clear(clr[1]), .header(hd1),
    .hdr_valid(hv1), .dest(dst[1]), .i_tdata(id[1]), .i_tlast(il[1]),
    .i_tvalid(iv[1]), .i_tready(ir1), .o_tdata(od1), .o_tlast(ol1),
    .o_tvalid(ov1), .o_tready(ordy[1]), .drop_count(dc1));

  axi_demux_n #(.NUM_CHAN(6), .WIDTH(16), .DEST_W(3),
    .DROP_INACTIVE(0)) u2 (
    .clk(clk), .reset_n(reset_n), .clear(clr[2]), .header(hd2),
    .hdr_valid(hv2), .dest(dst[2]), .i_tdata(id[2]), .i_tlast(il[2]),
    .i_tvalid(iv[2]), .i_tready(ir2), .o_tdata(od2), .o_tlast(ol2),
    .o_tvalid(ov2), .o_tready(ordy[2][5:0]), .drop_count(dc2));

  always_comb begin
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    hv[0] = hv0; hv[1] = hv1; hv[2] = hv2;
    hd[0] = hd0; hd[1] = hd1; hd[2] = hd2;
    dc[0] = dc0; dc[1] = dc1; dc[2] = dc2;
    ov[0] = ov0; ov[1] = ov1; ov[2] = {2'b00, ov2};
    ol[0] = ol0; ol[1] = ol1; ol[2] = {2'b00, ol2};
    for (int c = 0; c < 8; c++) begin
      od[0][c] = od0[c*16 +: 16];
      od[1][c] = od1[c*16 +: 16];
    end
    for (int c = 0; c < 6; c++) od[2][c] = od2[c*16 +: 16];
    od[2][6] = 16'h0;
    od[2][7] = 16'h0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_chan(input int k, input int d);
    if (k == 0) return d;
    if (k == 1) return (d < 4) ? d : -1;
    return (d < 6) ? d : 0;
  endfunction

  // scoreboard pop, AXI hold stability, one-hot and occupancy checks
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 8; c++) hold_v[k][c] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("onehot", 32'($onehot0(ov[k])), 32'd1);
        for (int c = 0; c < 8; c++) begin
          if (hold_v[k][c])
            chk("hold", {15'd0, ov[k][c], ol[k][c], od[k][c]},
                {15'd0, 1'b1, hold_d[k][c]});
          hold_v[k][c] = ov[k][c] && !ordy[k][c];
          hold_d[k][c] = {ol[k][c], od[k][c]};
          if (ov[k][c] && ordy[k][c]) begin
            if (q.size() == 0)
              chk("sb_unexp", {4'(k), 8'(c), 3'b0, ol[k][c], od[k][c]},
                  32'hFFFF_FFFF);
            else
              chk("sb_beat", {4'(k), 8'(c), 3'b0, ol[k][c], od[k][c]},
                  q.pop_front());
          end
        end
      end
      if (chk_occ) begin
        chk("skid_rdy", {31'd0, ir[1]}, {31'd0, occ < 2});
        occ = occ + int'(iv[1] && ir[1]) - int'(ov[1][3] && ordy[1][3]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) ordy[1][3] = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_acc(input int k, inout int cyc);
    int t;
    t = 0;
    @(negedge clk);
    while (!ir[k] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("acc_tmo", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    cyc += t + 1;
  endtask

  task automatic send_pkt(input int k, input int d, input int n,
                          input bit wiggle, output int cyc);
    int ch;
    ch = exp_chan(k, d);
    cyc = 0;
    dst[k] = 3'(d);
    for (int b = 0; b < n; b++) begin
      id[k] = 16'($urandom);
      il[k] = (b == n - 1);
      iv[k] = 1'b1;
      if (ch >= 0) q.push_back({4'(k), 8'(ch), 3'b0, il[k], id[k]});
      wait_acc(k, cyc);
      if (wiggle) dst[k] = 3'($urandom);
    end
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 2000) chk("drain_tmo", 32'(q.size()), 32'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      id[k] = '0; il[k] = 0; iv[k] = 0; clr[k] = 0;
      dst[k] = '0; ordy[k] = '1;
    end
    #1;
    chk("rst_ov0", 32'(ov[0]), 32'd0);
    chk("rst_ov1", 32'(ov[1]), 32'd0);
    chk("rst_hv1", 32'(hv[1]), 32'd0);
    chk("rst_rdy0", 32'(ir[0]), 32'd0);
    chk("rst_rdy1", 32'(ir[1]), 32'd1);
    chk("rst_dc1", 32'(dc[1]), 32'd0);
    #21 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // flat routing, 5 cycles per 4-beat packet, dest ignored after header
    for (int d = 0; d < 8; d++) begin
      send_pkt(0, d, 4, 1, cyc);
      chk("pkt_cyc", 32'(cyc), 32'd5);
    end
    send_pkt(0, 6, 1, 0, cyc);
    chk("single_cyc", 32'(cyc), 32'd2);
    drain();

    // clear during beat 2 of a 6-beat packet
    dst[0] = 3'd1;
    id[0] = 16'hA001; il[0] = 0; iv[0] = 1;
    q.push_back({4'd0, 8'd1, 4'd0, 16'hA001});
    wait_acc(0, cyc);
    id[0] = 16'hA002; clr[0] = 1;
    q.push_back({4'd0, 8'd1, 4'd0, 16'hA002});
    wait_acc(0, cyc);
    clr[0] = 0;
    id[0] = 16'hA003;
    q.push_back({4'd0, 8'd1, 4'd0, 16'hA003});
    @(negedge clk);
    chk("clr_ov", 32'(ov[0]), 32'd0);
    chk("clr_hv", 32'(hv[0]), 32'd1);
    chk("clr_hdr", 32'(hd[0]), 32'hA003);
    chk("clr_dc", 32'(dc[0]), 32'd0);
    wait_acc(0, cyc);
    for (int b = 4; b <= 6; b++) begin
      id[0] = 16'hA000 + 16'(b);
      il[0] = (b == 6);
      q.push_back({4'd0, 8'd1, 3'd0, il[0], id[0]});
      wait_acc(0, cyc);
    end
    iv[0] = 0; il[0] = 0;
    drain();

    // no-drop mode: out-of-range dest goes to channel 0
    send_pkt(2, 7, 3, 1, cyc);
    send_pkt(2, 4, 2, 1, cyc);
    drain();
    chk("nodrop_dc", 32'(dc[2]), 32'd0);

    // drop inactive channel, then deliver to an active one
    send_pkt(1, 5, 3, 0, cyc);
    drain();
    chk("drop_dc1", 32'(dc[1]), 32'd1);
    send_pkt(1, 2, 3, 0, cyc);
    drain();

    // skid buffer under random backpressure
    occ = 0;
    chk_occ = 1;
    rnd_en = 1;
    send_pkt(1, 3, 16, 0, cyc);
    drain();
    rnd_en = 0;
    chk_occ = 0;
    ordy[1] = '1;
    chk("occ_end", 32'(occ), 32'd0);

    // asynchronous reset mid-packet
    dst[1] = 3'd3; id[1] = 16'hBEEF; il[1] = 0; iv[1] = 1;
    ordy[1][3] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ov1", 32'(ov[1]), 32'd0);
    chk("arst_hv1", 32'(hv[1]), 32'd0);
    chk("arst_rdy1", 32'(ir[1]), 32'd1);
    chk("arst_dc1", 32'(dc[1]), 32'd0);
    iv[1] = 0;
    ordy[1] = '1;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // synchronous clear of the drop counter
    send_pkt(1, 6, 2, 0, cyc);
    drain();
    chk("pre_clr_dc", 32'(dc[1]), 32'd1);
    clr[1] = 1;
    @(posedge clk);
    #1;
    clr[1] = 0;
    chk("clr_dc1", 32'(dc[1]), 32'd0);

    for (int p = 0; p < 300; p++) send_pkt(1, 5, 1, 0, cyc);
    drain();
    chk("drop300", 32'(dc[1]), 32'd300);
    chk("sb_left", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
